// File: rtl/cp0_regfile.sv
// CP0 register file: Count/Compare timer, Status, Cause, EPC and PRId with exception and ERET sequencing.
// Register updates land on the next clk edge; rdata is combinational and never stalls any producer.
module cp0_regfile #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] PRID       = 32'h0001_8000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [4:0]            waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [4:0]            raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic [5:0]            int_i,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [DATA_WIDTH-1:0] exc_pc,
  input  logic                  exc_bd,
  input  logic                  eret,
  output logic [DATA_WIDTH-1:0] status,
  output logic [DATA_WIDTH-1:0] cause,
  output logic [DATA_WIDTH-1:0] epc,
  output logic [DATA_WIDTH-1:0] count,
  output logic [DATA_WIDTH-1:0] compare,
  output logic                  timer_int
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  localparam logic [DATA_WIDTH-1:0] STATUS_RST = DATA_WIDTH'(32'h1000_0000);

  logic                  sw_en;
  logic                  wr_count;
  logic                  wr_compare;
  logic                  wr_status;
  logic                  wr_cause;
  logic                  wr_epc;
  logic                  exl;
  logic                  timer_hit;
  logic [DATA_WIDTH-1:0] count_nxt;
  logic [DATA_WIDTH-1:0] status_nxt;
  logic [DATA_WIDTH-1:0] cause_nxt;
  logic [DATA_WIDTH-1:0] epc_nxt;

  // Exception or ERET in the same cycle swallows the MTC0 completely.
  assign sw_en      = we & ~exc_valid & ~eret;
  assign wr_count   = sw_en & (waddr == REG_COUNT);
  assign wr_compare = sw_en & (waddr == REG_COMPARE);
  assign wr_status  = sw_en & (waddr == REG_STATUS);
  assign wr_cause   = sw_en & (waddr == REG_CAUSE);
  assign wr_epc     = sw_en & (waddr == REG_EPC);

  assign exl       = status[1];
  assign timer_hit = (count == compare) && (compare != '0);

  always_comb begin
    count_nxt = wr_count ? wdata : count + DATA_WIDTH'(1);
  end

  always_comb begin
    status_nxt = status;
    if (exc_valid) begin
      status_nxt[1] = 1'b1;
    end else if (eret) begin
      status_nxt[1] = 1'b0;
    end else if (wr_status) begin
      status_nxt = wdata;
    end
  end

  always_comb begin
    epc_nxt = epc;
    if (exc_valid) begin
      if (!exl) begin
        epc_nxt = exc_bd ? exc_pc - DATA_WIDTH'(4) : exc_pc;
      end
    end else if (wr_epc && !eret) begin
      epc_nxt = wdata;
    end
  end

  // Only IP[1:0], IV and WP are software-writable; IP[7:2] always track the pins.
  always_comb begin
    cause_nxt = cause;
    if (exc_valid) begin
      cause_nxt[6:2] = exc_code;
      if (!exl) begin
        cause_nxt[31] = exc_bd;
      end
    end else if (wr_cause) begin
      cause_nxt[9:8]   = wdata[9:8];
      cause_nxt[23:22] = wdata[23:22];
    end
    cause_nxt[15:10] = {int_i[5] | timer_int, int_i[4:0]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= '0;
      compare   <= '0;
      status    <= STATUS_RST;
      cause     <= '0;
      epc       <= '0;
      timer_int <= 1'b0;
    end else begin
      count  <= count_nxt;
      status <= status_nxt;
      cause  <= cause_nxt;
      epc    <= epc_nxt;
      if (wr_compare) begin
        compare   <= wdata;
        timer_int <= 1'b0;
      end else if (timer_hit) begin
        timer_int <= 1'b1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (raddr)
      REG_COUNT:   rdata = count;
      REG_COMPARE: rdata = compare;
      REG_STATUS:  rdata = status;
      REG_CAUSE:   rdata = cause;
      REG_EPC:     rdata = epc;
      REG_PRID:    rdata = PRID;
      default:     rdata = '0;
    endcase
  end

endmodule

// File: doc/cp0_regfile.md
CP0_REGFILE -- requirements
Module: cp0_regfile

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of every data port and register.
REQ-002 Parameter PRID, 32'h0001_8000, constant returned for PRId reads.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 we  in  1  software write enable from the writeback stage (MTC0).
REQ-006 waddr  in  5  CP0 register number to write.
REQ-007 wdata  in  32  write data.
REQ-008 raddr  in  5  CP0 register number to read (MFC0).
REQ-009 rdata  out  32  read data for raddr.
REQ-010 int_i  in  6  hardware interrupt lines, level-sensitive.
REQ-011 exc_valid  in  1  memory stage reports an exception this cycle.
REQ-012 exc_code  in  5  ExcCode for exc_valid.
REQ-013 exc_pc  in  32  PC of the faulting instruction.
REQ-014 exc_bd  in  1  faulting instruction is in a branch delay slot.
REQ-015 eret  in  1  ERET retires this cycle.
REQ-016 status, cause, epc, count, compare  out  32 each  current register values (registered).
REQ-017 timer_int  out  1  timer interrupt pending.

Function
REQ-018 Implemented registers: Count=9, Compare=11, Status=12, Cause=13, EPC=14, PRId=15; all other numbers read 0 and ignore writes.
REQ-019 rdata is combinational from the current registers; a same-cycle write to raddr is not forwarded (old value returned).
REQ-020 Count increments by 1 every cycle, wrapping 32'hFFFF_FFFF -> 0; a software write to Count loads wdata instead of incrementing that cycle.
REQ-021 timer_int sets (sticky) the cycle after count == compare with compare != 0; a software write to Compare clears timer_int in the same edge and takes priority over setting.
REQ-022 Software write to Status loads all 32 bits.
REQ-023 Software write to Cause updates only bits 9:8, 22, 23; all other Cause bits are untouched.
REQ-024 Software write to EPC loads all 32 bits; writes to PRId are ignored.
REQ-025 Every cycle Cause[15:10] <= {int_i[5] | timer_int, int_i[4:0]}, independent of software writes.
REQ-026 Exception entry (exc_valid=1, Status[1] EXL=0): EPC <= exc_bd ? exc_pc-4 : exc_pc; Cause[31] <= exc_bd; Cause[6:2] <= exc_code; Status[1] <= 1.
REQ-027 Exception while EXL=1: only Cause[6:2] <= exc_code; EPC, Cause[31], Status unchanged.
REQ-028 eret=1 (without exc_valid): Status[1] <= 0; all else unchanged.
REQ-029 Priority per cycle: exc_valid > eret > software write; in an exc_valid or eret cycle the software write is discarded entirely (Count still increments, Cause[15:10] still samples).
REQ-030 exc_pc-4 arithmetic is 32-bit modulo (0 -> 32'hFFFF_FFFC).
REQ-031 All outputs other than rdata change only on the rising edge of clk.

Reset
REQ-032 When rst_n=0 at a rising edge: count=0, compare=0, status=32'h1000_0000, cause=0, epc=0, timer_int=0; inputs ignored that cycle.
REQ-033 Reset asserted mid-exception or mid-write wins; the first post-reset edge behaves from reset values (count becomes 1).

Verification
REQ-034 Reset, then 5 idle cycles -> count=5, status=32'h1000_0000, cause=0, rdata(raddr=15)=PRID.
REQ-035 Write Compare=10 at count=3 -> timer_int=1 the cycle after count=10, cause[15]=1; write Compare=20 -> timer_int=0 next edge.
REQ-036 exc_valid, exc_code=5'h0C, exc_pc=32'h0000_0040, exc_bd=1 with EXL=0 -> epc=32'h0000_003C, cause[31]=1, cause[6:2]=5'h0C, status[1]=1; second exception exc_code=5'h04 -> only cause[6:2]=5'h04.
REQ-037 Same cycle we=1 waddr=14 wdata=32'hDEAD_BEEF and exc_valid=1 exc_pc=32'h100 exc_bd=0 -> epc=32'h0000_0100.
REQ-038 Write Cause=32'hFFFF_FFFF with int_i=0 -> cause=32'h00C0_0300; then eret -> status[1]=0.
REQ-039 Write Count=32'hFFFF_FFFF -> next cycle count=0; rst_n=0 coincident with exc_valid -> epc=0, status=32'h1000_0000.
